uart_tx_frame: RTL and testbench

Parametrised UART transmitter and the next generation of the existing fixed 8N1 transmitter. Generates its own bit timing from CLK_FREQ/BAUD, so no external clk_bps or bps_start handshake is needed. Supports configurable data width, parity mode and stop-bit count. Accepts bytes over a valid/ready handshake and drives the serial line plus frame-status strobes toward the host-side logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_frame_if.sv | 28 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_tx_frame.sv | 139 +++++++++++++
 tb/tb_uart_tx_frame.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, TX state encoding and bit-period math.
// Intended for both the transmitter and future receive logic.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Rounded to the nearest integer so the baud error stays below half a clock per bit.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side bundle of the UART transmitter: payload handshake, serial line and frame status.
interface uart_tx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
) ();

    // Handshake: a payload transfers on any clock where in_valid && in_ready are both high;
    // in_ready never depends on in_valid, and the payload is not consumed otherwise.
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 uart_tx;
    logic                 busy;
    logic                 byte_end;
    tx_state_t            dbg_state;

    modport master (
        output in_data, in_valid,
        input  in_ready, uart_tx, busy, byte_end, dbg_state
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, uart_tx, busy, byte_end, dbg_state
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count and the clock before it.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // tick_next lets a consumer register a strobe that lands exactly on the terminal clock.
    assign tick      = !clear && (cnt == CW'(CLKS_PER_BIT - 1));
    assign tick_next = !clear && (cnt == CW'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional parity, 1 or 2 stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input logic            clk,
    input logic            rst,
    uart_tx_frame_if.slave bus
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
    localparam int BCW          = $clog2(DATA_BITS + 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_frame: CLK_FREQ/BAUD must give at least 2 clocks per bit");
    end

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [BCW-1:0]       bit_cnt;
    logic                 stop_cnt;
    logic                 par_bit;
    logic                 tx_r;
    logic                 busy_r;
    logic                 byte_end_r;
    logic                 tick;
    logic                 tick_next;
    logic                 stop_last;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == ST_IDLE),
        .tick     (tick),
        .tick_next(tick_next)
    );

    assign stop_last     = (stop_cnt == 1'(STOP_BITS - 1));
    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.uart_tx   = tx_r;
    assign bus.busy      = busy_r;
    assign bus.byte_end  = byte_end_r;
    assign bus.dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            par_bit    <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            byte_end_r <= 1'b0;
        end else begin
            byte_end_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        shreg   <= bus.in_data;
                        par_bit <= (PARITY == PAR_ODD) ? ~(^bus.in_data) : ^bus.in_data;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_r    <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= BCW'(1);
                        state   <= ST_DATA;
                    end
                end
                // bit_cnt holds the number of payload bits already placed on the line.
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == BCW'(DATA_BITS)) begin
                            if (PARITY != PAR_NONE) begin
                                tx_r  <= par_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx_r     <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= ST_STOP;
                            end
                        end else begin
                            tx_r    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        tx_r     <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick_next && stop_last) begin
                        byte_end_r <= 1'b1;
                    end
                    if (tick) begin
                        if (stop_last) begin
                            busy_r <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: five parameter variants sharing one clock and reset.
module tb_uart_tx_frame;
    import uart_pkg::*;

    logic       clk;
    logic       rst;
    logic       drv_valid;
    logic [7:0] drv_data;
    int         sel;
    int         n_cmp;
    int         n_err;

    logic       obs_tx;
    logic       obs_ready;
    logic       obs_busy;
    logic       obs_end;
    tx_state_t  obs_state;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT variants ----------------
    uart_tx_frame_if #(.DATA_BITS(8)) if0 ();
    uart_tx_frame_if #(.DATA_BITS(7)) if1 ();
    uart_tx_frame_if #(.DATA_BITS(7)) if2 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if3 ();
    uart_tx_frame_if #(.DATA_BITS(8)) if4 ();

    assign if0.in_valid = (sel == 0) && drv_valid;
    assign if1.in_valid = (sel == 1) && drv_valid;
    assign if2.in_valid = (sel == 2) && drv_valid;
    assign if3.in_valid = (sel == 3) && drv_valid;
    assign if4.in_valid = (sel == 4) && drv_valid;
    assign if0.in_data  = drv_data;
    assign if1.in_data  = drv_data[6:0];
    assign if2.in_data  = drv_data[6:0];
    assign if3.in_data  = drv_data;
    assign if4.in_data  = drv_data;

    uart_tx_frame #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    uart_tx_frame #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    uart_tx_frame #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    uart_tx_frame #(.CLK_FREQ(400), .BAUD(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
        u3 (.clk(clk), .rst(rst), .bus(if3));
    uart_tx_frame u4 (.clk(clk), .rst(rst), .bus(if4));

    always_comb begin
        obs_tx    = if0.uart_tx;
        obs_ready = if0.in_ready;
        obs_busy  = if0.busy;
        obs_end   = if0.byte_end;
        obs_state = if0.dbg_state;
        case (sel)
            1: begin
                obs_tx = if1.uart_tx; obs_ready = if1.in_ready; obs_busy = if1.busy;
                obs_end = if1.byte_end; obs_state = if1.dbg_state;
            end
            2: begin
                obs_tx = if2.uart_tx; obs_ready = if2.in_ready; obs_busy = if2.busy;
                obs_end = if2.byte_end; obs_state = if2.dbg_state;
            end
            3: begin
                obs_tx = if3.uart_tx; obs_ready = if3.in_ready; obs_busy = if3.busy;
                obs_end = if3.byte_end; obs_state = if3.dbg_state;
            end
            4: begin
                obs_tx = if4.uart_tx; obs_ready = if4.in_ready; obs_busy = if4.busy;
                obs_end = if4.byte_end; obs_state = if4.dbg_state;
            end
            default: ;
        endcase
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Call at a negedge with the selected DUT idle. line[i] is the i-th bit on the wire.
    // Returns at the negedge after the frame, where the line must be back to idle mark.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic [15:0] line,
                             input int nbits, input int cpb, input bit hold, input int glitch_at);
        int total;
        total     = nbits * cpb;
        drv_data  = data;
        drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) drv_valid = 1'b0;
        for (int k = 1; k <= total; k++) begin
            check($sformatf("%s tx clk%0d", tag, k), 32'(obs_tx), 32'(line[(k - 1) / cpb]));
            check($sformatf("%s ready clk%0d", tag, k), 32'(obs_ready), 32'd0);
            check($sformatf("%s busy clk%0d", tag, k), 32'(obs_busy), 32'd1);
            check($sformatf("%s byte_end clk%0d", tag, k), 32'(obs_end), (k == total) ? 32'd1 : 32'd0);
            if (glitch_at != 0 && k == glitch_at) begin
                drv_data  = ~data;
                drv_valid = 1'b1;
            end
            if (glitch_at != 0 && k == glitch_at + 1) begin
                drv_valid = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, " idle tx"}, 32'(obs_tx), 32'd1);
        check({tag, " idle ready"}, 32'(obs_ready), 32'd1);
        check({tag, " idle busy"}, 32'(obs_busy), 32'd0);
        check({tag, " idle byte_end"}, 32'(obs_end), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_cmp     = 0;
        n_err     = 0;
        sel       = 0;
        rst       = 1'b1;
        drv_valid = 1'b0;
        drv_data  = 8'h00;
        repeat (2) @(negedge clk);

        check("reset tx", 32'(obs_tx), 32'd1);
        check("reset ready", 32'(obs_ready), 32'd1);
        check("reset busy", 32'(obs_busy), 32'd0);
        check("reset byte_end", 32'(obs_end), 32'd0);
        check("reset state", 32'(obs_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1, 0xA5: 0,1,0,1,0,0,1,0,1,1 on the wire, 40 clocks
        run_frame("8n1_a5", 8'hA5, 16'b0000_0011_0100_1010, 10, 4, 1'b0, 0);

        // 7E1 and 7O1, 7'h03: parity 0 for even, 1 for odd
        sel = 1;
        @(negedge clk);
        run_frame("7e1_03", 8'h03, 16'b0000_0010_0000_0110, 10, 4, 1'b0, 0);
        sel = 2;
        @(negedge clk);
        run_frame("7o1_03", 8'h03, 16'b0000_0011_0000_0110, 10, 4, 1'b0, 0);

        // 8N2 back-to-back with in_valid held: one mark clock between frames
        sel = 3;
        @(negedge clk);
        run_frame("8n2_00", 8'h00, 16'b0000_0110_0000_0000, 11, 4, 1'b1, 0);
        run_frame("8n2_ff", 8'hFF, 16'b0000_0111_1111_1110, 11, 4, 1'b0, 0);

        // Reset while the first data bit (0) of 0x3C is on the line
        sel = 0;
        @(negedge clk);
        drv_data  = 8'h3C;
        drv_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre-reset tx", 32'(obs_tx), 32'd0);
        check("pre-reset state", 32'(obs_state), 32'(ST_DATA));
        rst = 1'b1;
        #1;
        check("async reset tx", 32'(obs_tx), 32'd1);
        check("async reset busy", 32'(obs_busy), 32'd0);
        check("async reset ready", 32'(obs_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check("post-reset state", 32'(obs_state), 32'(ST_IDLE));
        run_frame("8n1_81", 8'h81, 16'b0000_0011_0000_0010, 10, 4, 1'b0, 0);

        // in_data changed and in_valid pulsed mid-frame must not disturb 0x5A
        @(negedge clk);
        run_frame("8n1_5a_glitch", 8'h5A, 16'b0000_0010_1011_0100, 10, 4, 1'b0, 15);

        // Default parameters: 217 clocks per bit, 2170-clock frame
        sel = 4;
        @(negedge clk);
        check("default reset state", 32'(obs_state), 32'(ST_IDLE));
        run_frame("dflt_55", 8'h55, 16'b0000_0010_1010_1010, 10, 217, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
